// File: rtl/axi_brot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_brot_pkg
// Purpose  : Shared constants for the Mandelbrot accelerator register slave:
//            register word indices, AXI response code, STATUS and CTRL bit
//            positions, and the byte-strobe merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_brot_pkg;

    // Word indices (byte address bits [4:2])
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_C_REAL   = 3'd1;
    localparam logic [2:0] REG_C_IMAG   = 3'd2;
    localparam logic [2:0] REG_MAX_ITER = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // STATUS word layout
    localparam int STATUS_BUSY_BIT = 1;
    localparam int STATUS_DONE_BIT = 2;
    localparam int STATUS_ITER_LSB = 16;

    // CTRL bit that requests a core start
    localparam int CTRL_START_BIT = 0;

    // Byte-wise merge: bytes with a set strobe take the new data.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_brot_regs_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_brot_regs_slave
// Purpose  : AXI4-Lite responder for the Mandelbrot accelerator control and
//            status register file. Four RW config words (CTRL, C_REAL,
//            C_IMAG, MAX_ITER), one RO STATUS word, start pulse generation
//            and done/iteration capture from the iteration core.
// Ports    : S_AXI_*            AXI4-Lite slave port (clock, async reset,
//                               AW/W/B/AR/R channels)
//            core_start         one-cycle start pulse to the core
//            cfg_*              live copies of the four config words
//            core_busy          core running (reflected in STATUS[1])
//            core_done          completion pulse, latches core_iter
//            core_iter          final iteration count
// Revision : 1.0 - initial release
// ============================================================================
module axi_brot_regs_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            core_start,
    output logic [31:0]                     cfg_ctrl,
    output logic [31:0]                     cfg_c_real,
    output logic [31:0]                     cfg_c_imag,
    output logic [31:0]                     cfg_max_iter,
    input  logic                            core_busy,
    input  logic                            core_done,
    input  logic [15:0]                     core_iter
);
    import axi_brot_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        ready_en_q;      // keeps all READYs low until after reset
    logic        aw_held_q;
    logic [2:0]  aw_idx_q;
    logic        w_held_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q;
    logic [31:0] regs_q [0:3];
    logic        core_start_q;
    logic        sticky_done_q;
    logic [15:0] iter_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic        w_start_fire;
    logic [31:0] w_status;
    logic [31:0] rdata_d;

    // ------------------------------------------------------------------
    // Handshakes and commit qualification
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = ready_en_q & ~aw_held_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_held_q;
    assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;

    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A second commit is held off until the previous B response retires.
    assign w_commit = aw_held_q & w_held_q & ~bvalid_q;

    assign w_start_fire = w_commit
                        & (aw_idx_q == REG_CTRL)
                        & w_strb_q[0]
                        & w_data_q[CTRL_START_BIT]
                        & ~core_busy;

    // ------------------------------------------------------------------
    // Ready enable: one cycle after reset release
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write path: AW/W holding registers, commit, B channel, start pulse
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            aw_held_q    <= 1'b0;
            aw_idx_q     <= 3'd0;
            w_held_q     <= 1'b0;
            w_data_q     <= 32'd0;
            w_strb_q     <= 4'd0;
            bvalid_q     <= 1'b0;
            core_start_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            // Handshakes cannot coincide with commit: commit needs both
            // holds set, which forces the matching READY low.
            if (w_aw_hs) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[4:2];
            end
            if (w_w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end

            if (w_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                // Indices 4..7 are not writable; response is still OKAY.
                if (!aw_idx_q[2]) begin
                    regs_q[aw_idx_q[1:0]] <= strb_merge(regs_q[aw_idx_q[1:0]],
                                                        w_data_q, w_strb_q);
                end
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            core_start_q <= w_start_fire;
        end
    end

    // ------------------------------------------------------------------
    // Core status capture: a done in the same cycle as a start wins
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            sticky_done_q <= 1'b0;
            iter_q        <= 16'd0;
        end else if (core_done) begin
            sticky_done_q <= 1'b1;
            iter_q        <= core_iter;
        end else if (w_start_fire) begin
            sticky_done_q <= 1'b0;
        end
    end

    always_comb begin
        w_status                           = 32'd0;
        w_status[STATUS_ITER_LSB +: 16]    = iter_q;
        w_status[STATUS_DONE_BIT]          = sticky_done_q;
        w_status[STATUS_BUSY_BIT]          = core_busy;
    end

    // ------------------------------------------------------------------
    // Read path. The mux samples the registers before the edge, so a read
    // captured on a commit edge returns the pre-write value.
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = 32'd0;
        case (S_AXI_ARADDR[4:2])
            REG_CTRL:     rdata_d = regs_q[0];
            REG_C_REAL:   rdata_d = regs_q[1];
            REG_C_IMAG:   rdata_d = regs_q[2];
            REG_MAX_ITER: rdata_d = regs_q[3];
            REG_STATUS:   rdata_d = w_status;
            default:      rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (w_ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = AXI_RESP_OKAY;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = AXI_RESP_OKAY;

    assign core_start   = core_start_q;
    assign cfg_ctrl     = regs_q[0];
    assign cfg_c_real   = regs_q[1];
    assign cfg_c_imag   = regs_q[2];
    assign cfg_max_iter = regs_q[3];

    // Protection bits and byte-offset address bits carry no meaning here.
    logic w_unused;
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_axi_brot_regs_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_brot_regs_slave
// Purpose  : Directed self-checking bench for axi_brot_regs_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_brot_regs_slave;

    logic        clk;
    logic        rst;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        core_start;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_c_real;
    logic [31:0] cfg_c_imag;
    logic [31:0] cfg_max_iter;
    logic        core_busy;
    logic        core_done;
    logic [15:0] core_iter;

    int n_checks;
    int n_fail;
    int start_cnt;

    axi_brot_regs_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .core_start    (core_start),
        .cfg_ctrl      (cfg_ctrl),
        .cfg_c_real    (cfg_c_real),
        .cfg_c_imag    (cfg_c_imag),
        .cfg_max_iter  (cfg_max_iter),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .core_iter     (core_iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt++;
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write with AW and W presented together; B completes with BREADY=1.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic aw_hs;
        logic w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        if (awvalid || wvalid) begin
            n_checks++; n_fail++;
            $display("FAIL write_addr_timeout: addr %h not accepted", a);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL write_b_timeout: got bvalid=%b required 1", bvalid);
        end
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int   n;
        logic hs;
        araddr = a; arvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            hs = arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        if (!hs) begin
            n_checks++; n_fail++;
            $display("FAIL read_ar_timeout: addr %h not accepted", a);
        end
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!rvalid) begin
            n_checks++; n_fail++;
            $display("FAIL read_r_timeout: got rvalid=%b required 1", rvalid);
        end
        d = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid, core_start} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b required 000000",
                     {awready, wready, arready, bvalid, rvalid, core_start});
        end
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h required 00000000", rdata);
        end
        n_checks++;
        if (cfg_ctrl !== 32'h0 || cfg_max_iter !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cfg: got %h %h required 0 0", cfg_ctrl, cfg_max_iter);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL post_reset_ready: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_rw_all;
        logic [31:0] d;
        logic [1:0]  r;
        int          s0;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, r);
            n_checks++;
            if (r !== 2'b00) begin
                n_fail++;
                $display("FAIL rw_bresp[%0d]: got %b required 00", i, r);
            end
            if (i == 0) begin
                n_checks++;
                if (start_cnt !== s0 + 1) begin
                    n_fail++;
                    $display("FAIL rw_start_first: got %0d pulses required 1", start_cnt - s0);
                end
            end
        end
        n_checks++;
        if (start_cnt !== s0 + 1) begin
            n_fail++;
            $display("FAIL rw_start_once: got %0d pulses required 1", start_cnt - s0);
        end
        n_checks++;
        if ({cfg_ctrl, cfg_c_real, cfg_c_imag, cfg_max_iter} !==
            {32'h1, 32'h2, 32'h3, 32'h4}) begin
            n_fail++;
            $display("FAIL rw_cfg_outputs: got %h %h %h %h required 1 2 3 4",
                     cfg_ctrl, cfg_c_real, cfg_c_imag, cfg_max_iter);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r);
            n_checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                n_fail++;
                $display("FAIL rw_readback[%0d]: got %h/%b required %h/00", i, d, r, i + 1);
            end
        end
    endtask

    task automatic test_wstrb;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h04, 32'hAABBCCDD, 4'hF, r);
        axi_write(5'h04, 32'h11223344, 4'b0101, r);
        axi_read(5'h04, d, r);
        n_checks++;
        if (d !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL wstrb_merge: got %h required AA22CC44", d);
        end
        axi_write(5'h04, 32'hFFFFFFFF, 4'b0000, r);
        n_checks++;
        if (r !== 2'b00) begin
            n_fail++;
            $display("FAIL wstrb_zero_resp: got %b required 00", r);
        end
        axi_read(5'h04, d, r);
        n_checks++;
        if (d !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL wstrb_zero_nochange: got %h required AA22CC44", d);
        end
    endtask

    task automatic test_w_before_aw;
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b0;
        wdata = 32'h5555AAAA; wstrb = 4'hF; wvalid = 1'b1;
        n_checks++;
        if (wready !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_wready_initial: got %b required 1", wready);
        end
        tick();
        wvalid = 1'b0;
        n_checks++;
        if (wready !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_wready_drop: got %b required 0", wready);
        end
        repeat (2) tick();
        n_checks++;
        if (wready !== 1'b0 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_waiting: got wready=%b bvalid=%b required 0 0", wready, bvalid);
        end
        awaddr = 5'h08; awvalid = 1'b1;
        n_checks++;
        if (awready !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_awready: got %b required 1", awready);
        end
        tick();
        awvalid = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_b_early: got %b required 0", bvalid);
        end
        tick();
        n_checks++;
        if (bvalid !== 1'b1 || wready !== 1'b1 || awready !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_b_latency: got bvalid=%b wready=%b awready=%b required 1 1 1",
                     bvalid, wready, awready);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(5'h08, d, r);
        n_checks++;
        if (d !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL wfirst_data: got %h required 5555AAAA", d);
        end
    endtask

    task automatic test_read_backpressure;
        araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h4 || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL rbp_hold[%0d]: got rvalid=%b rdata=%h arready=%b required 1 4 0",
                         i, rvalid, rdata, arready);
            end
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++;
            $display("FAIL rbp_retire: got rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b0;
        awaddr = 5'h04; wdata = 32'h11111111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awaddr = 5'h08; wdata = 32'h22222222;
        tick();                       // first commit edge
        n_checks++;
        if (bvalid !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_commit: got bvalid=%b awready=%b wready=%b required 1 1 1",
                     bvalid, awready, wready);
        end
        tick();                       // second accepted while B pending
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || cfg_c_imag !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL b2b_stall: got bvalid=%b awready=%b wready=%b c_imag=%h required 1 0 0 5555AAAA",
                     bvalid, awready, wready, cfg_c_imag);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_retire: got bvalid=%b required 0", bvalid);
        end
        tick();
        n_checks++;
        if (bvalid !== 1'b1 || cfg_c_imag !== 32'h22222222) begin
            n_fail++;
            $display("FAIL b2b_second_commit: got bvalid=%b c_imag=%h required 1 22222222",
                     bvalid, cfg_c_imag);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(5'h04, d, r);
        n_checks++;
        if (d !== 32'h11111111) begin
            n_fail++;
            $display("FAIL b2b_read_first: got %h required 11111111", d);
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        logic [1:0]  r;
        bready = 1'b1;
        awaddr = 5'h04; wdata = 32'h33333333; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h04; arvalid = 1'b1;
        tick();                       // commit edge and AR handshake together
        arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h11111111) begin
            n_fail++;
            $display("FAIL collision_old_value: got rvalid=%b rdata=%h required 1 11111111", rvalid, rdata);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        axi_read(5'h04, d, r);
        n_checks++;
        if (d !== 32'h33333333) begin
            n_fail++;
            $display("FAIL collision_new_value: got %h required 33333333", d);
        end
    endtask

    task automatic test_status;
        logic [31:0] d;
        logic [1:0]  r;
        int          s0;
        core_done = 1'b1; core_iter = 16'h00FF;
        tick();
        core_done = 1'b0; core_iter = 16'h0000;
        axi_read(5'h10, d, r);
        n_checks++;
        if (d !== 32'h00FF0004) begin
            n_fail++;
            $display("FAIL status_done: got %h required 00FF0004", d);
        end
        s0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hF, r);
        axi_read(5'h10, d, r);
        n_checks++;
        if (d !== 32'h00FF0000 || start_cnt !== s0 + 1) begin
            n_fail++;
            $display("FAIL status_start_clears: got %h pulses=%0d required 00FF0000 1", d, start_cnt - s0);
        end
        axi_read(5'h00, d, r);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL ctrl_readback: got %h required 00000001", d);
        end
        core_busy = 1'b1;
        axi_read(5'h10, d, r);
        n_checks++;
        if (d !== 32'h00FF0002) begin
            n_fail++;
            $display("FAIL status_busy: got %h required 00FF0002", d);
        end
        s0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hF, r);
        core_busy = 1'b0;
        n_checks++;
        if (start_cnt !== s0) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d pulses required 0", start_cnt - s0);
        end
        axi_write(5'h00, 32'h1, 4'b1110, r);
        n_checks++;
        if (start_cnt !== s0) begin
            n_fail++;
            $display("FAIL start_no_strb0: got %0d pulses required 0", start_cnt - s0);
        end
        // core_done lands on the same edge as a start commit: done wins
        bready = 1'b1;
        awaddr = 5'h00; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        core_done = 1'b1; core_iter = 16'h0123;
        tick();
        core_done = 1'b0; core_iter = 16'h0000;
        tick();
        bready = 1'b0;
        axi_read(5'h10, d, r);
        n_checks++;
        if (d !== 32'h01230004 || start_cnt !== s0 + 1) begin
            n_fail++;
            $display("FAIL status_set_wins: got %h pulses=%0d required 01230004 1", d, start_cnt - s0);
        end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h14, 32'hDEADBEEF, 4'hF, r);
        n_checks++;
        if (r !== 2'b00) begin
            n_fail++;
            $display("FAIL unmapped_bresp: got %b required 00", r);
        end
        axi_read(5'h14, d, r);
        n_checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL unmapped_read5: got %h/%b required 00000000/00", d, r);
        end
        axi_read(5'h1C, d, r);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read7: got %h required 00000000", d);
        end
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, r);
        axi_read(5'h10, d, r);
        n_checks++;
        if (d !== 32'h01230004) begin
            n_fail++;
            $display("FAIL status_ro: got %h required 01230004", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        bready = 1'b0;
        awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_b_pending: got %b required 1", bvalid);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b0 || core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_bvalid: got bvalid=%b awready=%b start=%b required 0 0 0",
                     bvalid, awready, core_start);
        end
        rst = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            axi_read(5'(i * 4), d, r);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL rstmid_reg[%0d]: got %h required 00000000", i, d);
            end
        end
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_response: got bvalid=%b required 0", bvalid);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; start_cnt = 0;
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        core_busy = 1'b0; core_done = 1'b0; core_iter = '0;

        test_reset();
        test_rw_all();
        test_wstrb();
        test_w_before_aw();
        test_read_backpressure();
        test_back_to_back();
        test_collision();
        test_status();
        test_unmapped();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
